// File: rtl/udma_spi_slave_resp_if.sv
// Word-stream handshake between the SPI responder and its consumer/producer.
// The slave modport is the responder side; the master modport is the user side.
interface udma_spi_slave_resp_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] rx_data_o;
    logic                  rx_valid_o;
    logic                  rx_ready_i;
    logic [DATA_WIDTH-1:0] tx_data_i;
    logic                  tx_valid_i;
    logic                  tx_ready_o;

    modport slave (
        output rx_data_o,
        output rx_valid_o,
        input  rx_ready_i,
        input  tx_data_i,
        input  tx_valid_i,
        output tx_ready_o
    );

    modport master (
        input  rx_data_o,
        input  rx_valid_o,
        output rx_ready_i,
        output tx_data_i,
        output tx_valid_i,
        input  tx_ready_o
    );
endinterface

// File: rtl/udma_spi_slave_resp.sv
// SPI responder: oversamples the master's pins on sys_clk_i, deserialises MOSI
// into RX words and serialises TX words onto MISO, MSB first.
module udma_spi_slave_resp #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_WIDTH  = 32
) (
    input  logic       sys_clk_i,
    input  logic       rstn_i,
    input  logic       cfg_cpol_i,
    input  logic       cfg_cpha_i,
    input  logic [1:0] cfg_datasize_i,
    input  logic       spi_clk_i,
    input  logic       spi_csn_i,
    input  logic       spi_mosi_i,
    output logic       spi_miso_o,
    output logic       spi_miso_oe_o,
    udma_spi_slave_resp_if.slave stream,
    output logic       rx_overflow_o,
    output logic       tx_underflow_o,
    output logic       frame_abort_o,
    output logic       busy_o
);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    state_t state_reg, state_next;

    logic [2:0] pin_vec;
    logic [2:0] sync_out;
    logic       clk_d_reg, csn_d_reg;
    logic       clk_s, csn_s, mosi_s;

    logic                  cpol_reg, cpha_reg;
    logic [1:0]            ds_reg;
    logic [5:0]            cnt_reg;
    logic [DATA_WIDTH-1:0] tx_shift_reg;
    logic [DATA_WIDTH-1:0] rx_shift_reg;
    logic [DATA_WIDTH-1:0] rx_word_reg;
    logic [DATA_WIDTH-1:0] rx_data_reg;
    logic                  rx_valid_reg;
    logic                  word_done_reg;
    logic                  tx_ready_reg, tx_underflow_reg, rx_overflow_reg, frame_abort_reg;

    logic                  clk_rise, clk_fall, csn_fall, csn_rise;
    logic                  lead_edge, trail_edge;
    logic                  frame_start, frame_stop, sample_edge, shift_edge, do_load;
    logic [5:0]            word_bits;
    logic [5:0]            cnt_inc;
    logic                  word_end;
    logic [DATA_WIDTH-1:0] rx_shift_in;
    logic                  tx_msb;

    // Clock, CSN and MOSI travel through identical chains so they stay aligned.
    assign pin_vec = {spi_clk_i, spi_csn_i, spi_mosi_i};

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic [2:0] stage_reg;
            if (gi == 0) begin : g_first
                always_ff @(posedge sys_clk_i) begin
                    if (!rstn_i) stage_reg <= 3'b010;
                    else         stage_reg <= pin_vec;
                end
            end else begin : g_next
                always_ff @(posedge sys_clk_i) begin
                    if (!rstn_i) stage_reg <= 3'b010;
                    else         stage_reg <= g_sync[gi-1].stage_reg;
                end
            end
        end
    endgenerate

    assign sync_out = g_sync[SYNC_STAGES-1].stage_reg;
    assign clk_s    = sync_out[2];
    assign csn_s    = sync_out[1];
    assign mosi_s   = sync_out[0];

    always_ff @(posedge sys_clk_i) begin
        if (!rstn_i) begin
            clk_d_reg <= 1'b0;
            csn_d_reg <= 1'b1;
        end else begin
            clk_d_reg <= clk_s;
            csn_d_reg <= csn_s;
        end
    end

    assign clk_rise   = clk_s & ~clk_d_reg;
    assign clk_fall   = ~clk_s & clk_d_reg;
    assign csn_fall   = ~csn_s & csn_d_reg;
    assign csn_rise   = csn_s & ~csn_d_reg;
    assign lead_edge  = cpol_reg ? clk_fall : clk_rise;
    assign trail_edge = cpol_reg ? clk_rise : clk_fall;

    assign frame_start = (state_reg == IDLE) && csn_fall;
    assign frame_stop  = (state_reg == ACTIVE) && csn_rise;
    // CSN release wins over any SPI edge seen in the same cycle.
    assign sample_edge = (state_reg == ACTIVE) && !csn_rise && (cpha_reg ? trail_edge : lead_edge);
    assign shift_edge  = (state_reg == ACTIVE) && !csn_rise && (cpha_reg ? lead_edge : trail_edge);
    assign do_load     = (frame_start && !cfg_cpha_i) || (shift_edge && (cnt_reg == 6'd0));

    always_comb begin
        word_bits = 6'd32;
        tx_msb    = tx_shift_reg[31];
        case (ds_reg)
            2'b00: begin word_bits = 6'd8;  tx_msb = tx_shift_reg[7];  end
            2'b01: begin word_bits = 6'd16; tx_msb = tx_shift_reg[15]; end
            default: ;
        endcase
    end

    assign cnt_inc     = cnt_reg + 6'd1;
    assign word_end    = sample_edge && (cnt_inc == word_bits);
    assign rx_shift_in = {rx_shift_reg[DATA_WIDTH-2:0], mosi_s};

    function automatic logic [DATA_WIDTH-1:0] mask_word(input logic [1:0] ds,
                                                        input logic [DATA_WIDTH-1:0] w);
        case (ds)
            2'b00:   return {24'd0, w[7:0]};
            2'b01:   return {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

    always_ff @(posedge sys_clk_i) begin
        if (!rstn_i) state_reg <= IDLE;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (csn_fall) state_next = ACTIVE;
            ACTIVE:  if (csn_rise) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy_o        = 1'b0;
        spi_miso_oe_o = 1'b0;
        spi_miso_o    = 1'b0;
        if (state_reg == ACTIVE) begin
            busy_o        = 1'b1;
            spi_miso_oe_o = 1'b1;
            spi_miso_o    = tx_msb;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (!rstn_i) begin
            cpol_reg         <= 1'b0;
            cpha_reg         <= 1'b0;
            ds_reg           <= 2'b00;
            cnt_reg          <= 6'd0;
            tx_shift_reg     <= '0;
            rx_shift_reg     <= '0;
            rx_word_reg      <= '0;
            rx_data_reg      <= '0;
            rx_valid_reg     <= 1'b0;
            word_done_reg    <= 1'b0;
            tx_ready_reg     <= 1'b0;
            tx_underflow_reg <= 1'b0;
            rx_overflow_reg  <= 1'b0;
            frame_abort_reg  <= 1'b0;
        end else begin
            word_done_reg    <= word_end;
            frame_abort_reg  <= frame_stop && (cnt_reg != 6'd0);
            tx_ready_reg     <= do_load && stream.tx_valid_i;
            tx_underflow_reg <= do_load && !stream.tx_valid_i;
            rx_overflow_reg  <= word_done_reg && rx_valid_reg && !stream.rx_ready_i;

            if (do_load)         tx_shift_reg <= stream.tx_valid_i ? stream.tx_data_i : '0;
            else if (shift_edge) tx_shift_reg <= {tx_shift_reg[DATA_WIDTH-2:0], 1'b0};

            if (frame_start) begin
                cpol_reg     <= cfg_cpol_i;
                cpha_reg     <= cfg_cpha_i;
                ds_reg       <= cfg_datasize_i;
                cnt_reg      <= 6'd0;
                rx_shift_reg <= '0;
            end else if (frame_stop) begin
                cnt_reg <= 6'd0;
            end else if (sample_edge) begin
                rx_shift_reg <= rx_shift_in;
                cnt_reg      <= word_end ? 6'd0 : cnt_inc;
                if (word_end) rx_word_reg <= mask_word(ds_reg, rx_shift_in);
            end

            // A completed word may replace a word being consumed in this same cycle.
            if (word_done_reg) begin
                if (!rx_valid_reg || stream.rx_ready_i) begin
                    rx_data_reg  <= rx_word_reg;
                    rx_valid_reg <= 1'b1;
                end
            end else if (rx_valid_reg && stream.rx_ready_i) begin
                rx_valid_reg <= 1'b0;
            end
        end
    end

    assign stream.rx_data_o  = rx_data_reg;
    assign stream.rx_valid_o = rx_valid_reg;
    assign stream.tx_ready_o = tx_ready_reg;
    assign rx_overflow_o     = rx_overflow_reg;
    assign tx_underflow_o    = tx_underflow_reg;
    assign frame_abort_o     = frame_abort_reg;

endmodule

// File: tb/tb_udma_spi_slave_resp.sv
// Bench for the SPI responder: a bit-banged SPI master, a TX feeder queue and
// an RX scoreboard, driven from a vector table plus multi-word corner sequences.
module tb_udma_spi_slave_resp;

    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       cfg_cpol = 1'b0, cfg_cpha = 1'b0;
    logic [1:0] cfg_ds = 2'b00;
    logic       spi_clk = 1'b0, spi_csn = 1'b1, spi_mosi = 1'b0;
    logic       spi_miso, spi_miso_oe;
    logic       rx_overflow, tx_underflow, frame_abort, busy;
    logic       cpol = 1'b0, cpha = 1'b0;

    int checks = 0;
    int errors = 0;
    int n_txready = 0, n_under = 0, n_over = 0, n_abort = 0;

    logic [31:0] rx_q[$];
    logic [31:0] tx_q[$];

    udma_spi_slave_resp_if #(.DATA_WIDTH(32)) bus ();

    udma_spi_slave_resp #(.SYNC_STAGES(2), .DATA_WIDTH(32)) dut (
        .sys_clk_i      (clk),
        .rstn_i         (rstn),
        .cfg_cpol_i     (cfg_cpol),
        .cfg_cpha_i     (cfg_cpha),
        .cfg_datasize_i (cfg_ds),
        .spi_clk_i      (spi_clk),
        .spi_csn_i      (spi_csn),
        .spi_mosi_i     (spi_mosi),
        .spi_miso_o     (spi_miso),
        .spi_miso_oe_o  (spi_miso_oe),
        .stream         (bus),
        .rx_overflow_o  (rx_overflow),
        .tx_underflow_o (tx_underflow),
        .frame_abort_o  (frame_abort),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pulse counters, RX scoreboard and TX feeder all run on the falling edge.
    always @(negedge clk) begin
        if (bus.tx_ready_o)   n_txready++;
        if (tx_underflow)     n_under++;
        if (rx_overflow)      n_over++;
        if (frame_abort)      n_abort++;
        if (bus.rx_valid_o && bus.rx_ready_i) begin
            if (rx_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: got %h expected no word", bus.rx_data_o);
            end else begin
                check("rx_word", bus.rx_data_o, rx_q.pop_front());
            end
            $display("rx word %h", bus.rx_data_o);
        end
        if (bus.tx_ready_o && tx_q.size() != 0) void'(tx_q.pop_front());
        if (tx_q.size() != 0) begin
            bus.tx_valid_i = 1'b1;
            bus.tx_data_i  = tx_q[0];
        end else begin
            bus.tx_valid_i = 1'b0;
            bus.tx_data_i  = 32'h0;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_begin();
        spi_clk = cpol;
        wait_cyc(HALF);
        spi_csn = 1'b0;
        wait_cyc(HALF);
    endtask

    task automatic frame_end();
        wait_cyc(HALF);
        spi_csn = 1'b1;
        wait_cyc(12);
    endtask

    task automatic xfer_word(input logic [31:0] w, input int nbits, output logic [31:0] r);
        r = 32'h0;
        for (int i = nbits - 1; i >= 0; i--) begin
            if (!cpha) begin
                spi_mosi = w[i];
                wait_cyc(HALF);
                spi_clk = ~cpol;
                r = {r[30:0], spi_miso};
                wait_cyc(HALF);
                spi_clk = cpol;
            end else begin
                spi_clk  = ~cpol;
                spi_mosi = w[i];
                wait_cyc(HALF);
                spi_clk = cpol;
                r = {r[30:0], spi_miso};
                wait_cyc(HALF);
            end
        end
    endtask

    task automatic drain_rx(input string name);
        for (int k = 0; k < 40 && rx_q.size() != 0; k++) @(negedge clk);
        check(name, rx_q.size(), 0);
    endtask

    typedef struct {
        logic        cpol;
        logic        cpha;
        logic [1:0]  ds;
        int          nbits;
        logic        tx_valid;
        logic [31:0] tx_word;
        logic [31:0] mosi_word;
        logic [31:0] exp_rx;
        logic [31:0] exp_miso;
        int          exp_txready;
        int          exp_under;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [31:0] got;
        int t0, u0, o0, a0;

        // With CPHA=0 the trailing edge after the last sample loads again; the
        // TX queue is empty by then, so that load counts as one underflow.
        vecs[0] = '{1'b0, 1'b0, 2'b00,  8, 1'b1, 32'h000000A5, 32'h0000003C, 32'h0000003C, 32'h000000A5, 1, 1};
        vecs[1] = '{1'b1, 1'b1, 2'b10, 32, 1'b1, 32'hDEADBEEF, 32'h12345678, 32'h12345678, 32'hDEADBEEF, 1, 0};
        vecs[2] = '{1'b0, 1'b1, 2'b00,  8, 1'b0, 32'h00000000, 32'h0000003C, 32'h0000003C, 32'h00000000, 0, 1};
        vecs[3] = '{1'b1, 1'b0, 2'b01, 16, 1'b1, 32'hFFFFC3A5, 32'h00008001, 32'h00008001, 32'h0000C3A5, 1, 1};
        vecs[4] = '{1'b0, 1'b1, 2'b01, 16, 1'b1, 32'h00005A5A, 32'hABCDF00F, 32'h0000F00F, 32'h00005A5A, 1, 0};
        vecs[5] = '{1'b0, 1'b0, 2'b11, 32, 1'b1, 32'h80000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1, 1};

        bus.rx_ready_i = 1'b1;
        bus.tx_valid_i = 1'b0;
        bus.tx_data_i  = 32'h0;

        wait_cyc(5);
        check("reset_outputs", {busy, spi_miso_oe, spi_miso, bus.rx_valid_o, bus.tx_ready_o,
                                rx_overflow, tx_underflow, frame_abort}, 0);
        check("reset_rx_data", bus.rx_data_o, 0);
        rstn = 1'b1;
        wait_cyc(5);
        check("idle_busy", busy, 0);

        for (int v = 0; v < 6; v++) begin
            cpol = vecs[v].cpol; cpha = vecs[v].cpha;
            cfg_cpol = cpol; cfg_cpha = cpha; cfg_ds = vecs[v].ds;
            if (vecs[v].tx_valid) tx_q.push_back(vecs[v].tx_word);
            rx_q.push_back(vecs[v].exp_rx);
            t0 = n_txready; u0 = n_under; o0 = n_over; a0 = n_abort;
            frame_begin();
            check("busy_in_frame", {busy, spi_miso_oe}, 2'b11);
            // Mid-frame config changes must not disturb the latched settings.
            cfg_cpol = ~cpol; cfg_cpha = ~cpha; cfg_ds = ~vecs[v].ds;
            xfer_word(vecs[v].mosi_word, vecs[v].nbits, got);
            frame_end();
            $display("vec %0d: mosi %h miso %h", v, vecs[v].mosi_word, got);
            check("miso_word", got, vecs[v].exp_miso);
            check("idle_after", {busy, spi_miso_oe, spi_miso}, 0);
            check("tx_ready_cnt", n_txready - t0, vecs[v].exp_txready);
            check("underflow_cnt", n_under - u0, vecs[v].exp_under);
            check("no_overflow", n_over - o0, 0);
            check("no_abort", n_abort - a0, 0);
            drain_rx("rx_delivered");
        end

        // Three back-to-back 16-bit words in one frame, consumer always ready.
        cpol = 1'b0; cpha = 1'b1; cfg_cpol = 1'b0; cfg_cpha = 1'b1; cfg_ds = 2'b01;
        t0 = n_txready; u0 = n_under; o0 = n_over;
        for (int i = 0; i < 3; i++) begin
            tx_q.push_back(32'hA001 + i);
            rx_q.push_back(32'h1111 * (i + 1));
        end
        frame_begin();
        for (int i = 0; i < 3; i++) begin
            xfer_word(32'h1111 * (i + 1), 16, got);
            $display("burst word %0d: miso %h", i, got);
            check("burst_miso", got, 32'hA001 + i);
        end
        frame_end();
        check("burst_tx_ready", n_txready - t0, 3);
        check("burst_underflow", n_under - u0, 0);
        check("burst_overflow", n_over - o0, 0);
        drain_rx("burst_rx");

        // Consumer stalled: second word must be dropped with one overflow pulse.
        bus.rx_ready_i = 1'b0;
        cfg_ds = 2'b00;
        o0 = n_over;
        tx_q.push_back(32'hF0);
        tx_q.push_back(32'h0F);
        rx_q.push_back(32'h01);
        frame_begin();
        xfer_word(32'h01, 8, got);
        xfer_word(32'h02, 8, got);
        frame_end();
        $display("overflow frame: rx_valid %b rx_data %h", bus.rx_valid_o, bus.rx_data_o);
        check("ovf_valid_held", bus.rx_valid_o, 1);
        check("ovf_data_kept", bus.rx_data_o, 32'h01);
        check("ovf_pulse_cnt", n_over - o0, 1);
        bus.rx_ready_i = 1'b1;
        drain_rx("ovf_delivered");
        wait_cyc(2);
        check("ovf_valid_clear", bus.rx_valid_o, 0);

        // CSN raised after 5 of 8 bits, then a clean frame.
        cpol = 1'b0; cpha = 1'b0; cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_ds = 2'b00;
        a0 = n_abort;
        tx_q.push_back(32'h77);
        frame_begin();
        xfer_word(32'h1F, 5, got);
        frame_end();
        $display("abort frame: aborts %0d", n_abort - a0);
        check("abort_pulse", n_abort - a0, 1);
        check("abort_no_rx", bus.rx_valid_o, 0);
        a0 = n_abort;
        tx_q.push_back(32'h99);
        rx_q.push_back(32'h55);
        frame_begin();
        xfer_word(32'h55, 8, got);
        frame_end();
        check("post_abort_miso", got, 32'h99);
        check("post_abort_no_abort", n_abort - a0, 0);
        drain_rx("post_abort_rx");

        // Reset in the middle of a frame: everything returns to zero, no abort.
        a0 = n_abort;
        frame_begin();
        xfer_word(32'hFF, 3, got);
        rstn = 1'b0;
        wait_cyc(3);
        check("midreset_outputs", {busy, spi_miso_oe, spi_miso, bus.rx_valid_o, frame_abort}, 0);
        spi_csn = 1'b1;
        spi_clk = 1'b0;
        wait_cyc(2);
        rstn = 1'b1;
        wait_cyc(8);
        check("midreset_no_abort", n_abort - a0, 0);
        check("midreset_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/udma_spi_slave_resp.md
Name: udma_spi_slave_resp

Overview:
- SPI responder (slave) for the far end of the uDMA SPI master pin interface.
- Receives spi_clk, csn0 and sdo0 from the master and drives the master's sdi0.
- Oversamples all SPI pins on the system clock and deserialises MOSI into words on a valid/ready RX port.
- Serialises words from a valid/ready TX port onto MISO.
- Used as the bench-side and SoC-loopback counterpart of the SPI master.

Parameters:
- SYNC_STAGES, 2, synchroniser depth for spi_clk_i, spi_csn_i and spi_mosi_i; all three use the same depth.
- DATA_WIDTH, 32, width of the RX/TX data ports; fixed at 32.

Ports:
- sys_clk_i  in  1  system clock
- rstn_i  in  1  synchronous active-low reset
- cfg_cpol_i  in  1  clock polarity
- cfg_cpha_i  in  1  clock phase
- cfg_datasize_i  in  2  word size: 00 = 8, 01 = 16, 10 = 32, 11 = 32
- spi_clk_i  in  1  SPI clock from master
- spi_csn_i  in  1  chip select, active low
- spi_mosi_i  in  1  master data out (sdo0)
- spi_miso_o  out  1  slave data to master (sdi0)
- spi_miso_oe_o  out  1  MISO output enable
- rx_data_o  out  32  received word, right-aligned, zero-extended
- rx_valid_o  out  1  RX word valid
- rx_ready_i  in  1  RX consumer ready
- tx_data_i  in  32  word to transmit, right-aligned
- tx_valid_i  in  1  TX word available
- tx_ready_o  out  1  TX word consumed (1-cycle pulse)
- rx_overflow_o  out  1  1-cycle pulse: completed word dropped
- tx_underflow_o  out  1  1-cycle pulse: zero word loaded
- frame_abort_o  out  1  1-cycle pulse: CSN deasserted mid-word
- busy_o  out  1  frame active

Behaviour:
- Reset: with rstn_i low at a sys_clk_i edge, every output is 0, bit counter 0, shift registers 0, FSM in IDLE.
- Synchronisers: spi_clk_i, spi_csn_i and spi_mosi_i each pass through SYNC_STAGES flops. Edge detection compares the last synchronised stage with one extra flop.
- Edge mapping:
  - Leading edge = rising if CPOL=0, falling if CPOL=1.
  - CPHA=0: sample on leading edge, shift on trailing edge.
  - CPHA=1: shift on leading edge, sample on trailing edge.
- Timing requirement: SPI clock high and low times are each at least 4 sys_clk_i cycles. CSN fall to first SPI edge is at least 4 cycles.
- FSM IDLE -> ACTIVE: on synchronised CSN falling edge.
  - Latch cfg_cpol_i, cfg_cpha_i and cfg_datasize_i; config changes during a frame are ignored.
  - Clear the bit counter.
  - Set busy_o and spi_miso_oe_o.
  - If CPHA=0, perform a TX load in the same cycle.
- TX load: if tx_valid_i=1, capture tx_data_i and pulse tx_ready_o. Otherwise load 0 and pulse tx_underflow_o.
  - spi_miso_o always equals shift-register bit [N-1], where N is the latched word size (MSB first).
- Shift edge:
  - If the bit counter is 0, perform a TX load (this covers the first leading edge for CPHA=1 and word boundaries for both modes).
  - Otherwise shift the TX register left by 1.
- Sample edge: shift the synchronised MOSI into the RX register LSB first-in (so the MSB ends up at bit N-1), then increment the bit counter. When the counter reaches N, wrap it to 0 and complete the word.
- Word completion, on the next cycle:
  - If rx_valid_o=0, or rx_ready_i=1 in the completion cycle: update rx_data_o, set rx_valid_o=1.
  - Otherwise keep the old word and pulse rx_overflow_o.
- RX handshake: rx_valid_o clears on a cycle with rx_valid_o and rx_ready_i both high, unless a new word completes in that same cycle (then it stays high with the new data).
- Latency: rx_valid_o rises at most SYNC_STAGES+2 sys_clk_i cycles after the final sample SPI edge.
- Consequence of the TX load rule: with CPHA=0, the trailing edge after a word's last sample loads the next TX word even if no further clocks follow.
- FSM ACTIVE -> IDLE: on synchronised CSN rising edge.
  - If the bit counter is not 0, discard the partial word and pulse frame_abort_o.
  - Clear busy_o and spi_miso_oe_o; spi_miso_o goes to 0.
  - A pending rx_valid_o is retained.
- SPI edges while in IDLE are ignored.
- Reset mid-frame returns to IDLE with all outputs 0; no abort pulse.

Test Plan:
- CPOL=0, CPHA=0, 8-bit; TX 0xA5 preloaded; master sends 0x3C -> master receives 0xA5; rx_data_o=0x0000003C; one tx_ready_o pulse; no errors.
- CPOL=1, CPHA=1, 32-bit; TX 0xDEADBEEF; master sends 0x12345678 -> MISO 0xDEADBEEF MSB first; rx_data_o=0x12345678.
- 16-bit, three back-to-back words 0x1111, 0x2222, 0x3333 in one frame with rx_ready_i tied 1 -> three rx_valid_o pulses in order; three TX loads; no errors.
- rx_ready_i held 0, two 8-bit words 0x01, 0x02 -> rx_data_o stays 0x01; one rx_overflow_o pulse; 0x01 delivered when rx_ready_i rises.
- tx_valid_i held 0, 8-bit frame -> master receives 0x00; one tx_underflow_o pulse; RX still 0x3C correct.
- CSN raised after 5 of 8 clocks -> frame_abort_o pulse; no rx_valid_o; next full frame 0x55 received correctly.
